// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment scanner with dead-time and a frame-synchronous double buffer.
// Optional feature: define SEG_SCAN_LZB_EN to blank leading zero digits.

module all_to_segment (
    input  logic [4:0] sym,
    output logic [6:0] seg
);
    // Active-low segments, bit order {g,f,e,d,c,b,a}; 16..23 are glyphs, the rest blank.
    always_comb begin
        seg = 7'h7F;
        case (sym)
            5'd0:  seg = 7'h40;
            5'd1:  seg = 7'h79;
            5'd2:  seg = 7'h24;
            5'd3:  seg = 7'h30;
            5'd4:  seg = 7'h19;
            5'd5:  seg = 7'h12;
            5'd6:  seg = 7'h02;
            5'd7:  seg = 7'h78;
            5'd8:  seg = 7'h00;
            5'd9:  seg = 7'h10;
            5'd10: seg = 7'h08;
            5'd11: seg = 7'h03;
            5'd12: seg = 7'h46;
            5'd13: seg = 7'h21;
            5'd14: seg = 7'h06;
            5'd15: seg = 7'h0E;
            5'd16: seg = 7'h3F;
            5'd17: seg = 7'h09;
            5'd18: seg = 7'h47;
            5'd19: seg = 7'h0C;
            5'd20: seg = 7'h41;
            5'd21: seg = 7'h2B;
            5'd22: seg = 7'h23;
            5'd23: seg = 7'h2F;
            default: seg = 7'h7F;
        endcase
    end
endmodule

module seg_scan_mux #(
    parameter  int N_DIG = 4,
    parameter  int SYM_W = 5,
    parameter  int DIV   = 1024,
    parameter  int DEAD  = 2,
    localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [N_DIG*SYM_W-1:0] disps,
    input  logic                   load,
    output logic [N_DIG-1:0]       AN,
    output logic [6:0]             seven_out,
    output logic [SYM_W-1:0]       sym_out,
    output logic [IDX_W-1:0]       digit_idx,
    output logic                   frame_done
);
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] PCNT_MAX = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(N_DIG - 1);

    logic [CNT_W-1:0]       pcnt;
    logic [IDX_W-1:0]       idx;
    logic [N_DIG*SYM_W-1:0] active;
    logic [N_DIG*SYM_W-1:0] pending;
    logic                   pend_v;
    logic                   blank;
    logic [SYM_W-1:0]       fields [N_DIG];
    logic [N_DIG-1:0]       an_next;
    logic [6:0]             seg_dec;
    logic                   in_dead;
    logic                   slot_lzb;
    logic                   lit;
    logic                   frame_end;
    logic                   commit;

    // Field 0 is the top of the word, i.e. the leftmost digit.
    generate
        for (genvar gi = 0; gi < N_DIG; gi++) begin : g_field
            assign fields[gi] = active[(N_DIG-gi)*SYM_W-1 -: SYM_W];
        end
    endgenerate

    generate
        if (DEAD == 0) begin : g_no_dead
            assign in_dead = 1'b0;
        end else begin : g_dead
            assign in_dead = (pcnt < CNT_W'(DEAD));
        end
    endgenerate

`ifdef SEG_SCAN_LZB_EN
    // zero_pre[i]: fields 0..i are all zero.
    logic [N_DIG-1:0] zero_pre;
    generate
        for (genvar gi = 0; gi < N_DIG; gi++) begin : g_lzb
            if (gi == 0) begin : g_first
                assign zero_pre[gi] = (fields[gi] == '0);
            end else begin : g_rest
                assign zero_pre[gi] = zero_pre[gi-1] && (fields[gi] == '0);
            end
        end
    endgenerate
    assign slot_lzb = zero_pre[idx] && (idx != IDX_MAX);
`else
    assign slot_lzb = 1'b0;
`endif

    assign lit       = enable && !in_dead && !slot_lzb;
    assign frame_end = enable && (pcnt == PCNT_MAX) && (idx == IDX_MAX);
    // While disabled nothing is on the panel, so loads may land in active immediately.
    assign commit    = frame_end || !enable;

    generate
        for (genvar gi = 0; gi < N_DIG; gi++) begin : g_an
            assign an_next[N_DIG-1-gi] = !(lit && (idx == IDX_W'(gi)));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt       <= '0;
            idx        <= '0;
            active     <= '0;
            pending    <= '0;
            pend_v     <= 1'b0;
            AN         <= '1;
            blank      <= 1'b1;
            sym_out    <= '0;
            digit_idx  <= '0;
            frame_done <= 1'b0;
        end else begin
            if (!enable) begin
                pcnt <= '0;
                idx  <= '0;
            end else if (pcnt == PCNT_MAX) begin
                pcnt <= '0;
                idx  <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            end else begin
                pcnt <= pcnt + 1'b1;
            end

            if (commit) begin
                if (load)
                    active <= disps;
                else if (pend_v)
                    active <= pending;
                pend_v <= 1'b0;
            end else if (load) begin
                pending <= disps;
                pend_v  <= 1'b1;
            end

            AN         <= an_next;
            blank      <= &an_next;
            sym_out    <= fields[idx];
            digit_idx  <= idx;
            frame_done <= frame_end;
        end
    end

    all_to_segment u_dec (
        .sym (sym_out),
        .seg (seg_dec)
    );

    assign seven_out = blank ? 7'h7F : seg_dec;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomized scoreboard bench for seg_scan_mux; reference model works on frame position arithmetic.
// Build with SEG_SCAN_LZB_EN defined to check leading-zero blanking expectations.

module tb_seg_scan_mux;
    localparam int N_DIG = 4;
    localparam int SYM_W = 5;
    localparam int DIV   = 8;
    localparam int DEAD  = 2;
    localparam int FRAME = N_DIG * DIV;

    localparam logic [6:0] SEG_TAB [32] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
        7'h3F, 7'h09, 7'h47, 7'h0C, 7'h41, 7'h2B, 7'h23, 7'h2F,
        7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
    };

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   enable = 1'b0;
    logic [N_DIG*SYM_W-1:0] disps = '0;
    logic                   load = 1'b0;
    logic [N_DIG-1:0]       AN;
    logic [6:0]             seven_out;
    logic [SYM_W-1:0]       sym_out;
    logic [1:0]             digit_idx;
    logic                   frame_done;

    seg_scan_mux #(.N_DIG(N_DIG), .SYM_W(SYM_W), .DIV(DIV), .DEAD(DEAD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .disps      (disps),
        .load       (load),
        .AN         (AN),
        .seven_out  (seven_out),
        .sym_out    (sym_out),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fd;
        logic       lit;
        logic [4:0] sym;
        logic [1:0] didx;
    } exp_t;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int unsigned            pos = 0;   // position within frame of the next edge
    logic [N_DIG*SYM_W-1:0] m_active  = '0;
    logic [N_DIG*SYM_W-1:0] m_pending = '0;
    bit                     m_pv = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [4:0] field_of(input logic [N_DIG*SYM_W-1:0] v, input int slot);
        logic [N_DIG*SYM_W-1:0] sh;
        sh = v >> ((N_DIG - 1 - slot) * SYM_W);
        return sh[4:0];
    endfunction

    function automatic bit leading_zero(input logic [N_DIG*SYM_W-1:0] v, input int slot);
`ifdef SEG_SCAN_LZB_EN
        if (slot == N_DIG - 1) return 0;
        for (int k = 0; k <= slot; k++)
            if (field_of(v, k) != 0) return 0;
        return 1;
`else
        return 0;
`endif
    endfunction

    // Reference model: one expected output word per clock edge.
    always @(posedge clk) begin
        exp_t e;
        int   slot, phase;
        bit   boundary;
        if (!rst_n) begin
            e = '{an: 4'hF, seg: 7'h7F, fd: 1'b0, lit: 1'b0, sym: 5'd0, didx: 2'd0};
            pos = 0; m_active = '0; m_pending = '0; m_pv = 0;
        end else begin
            slot  = pos / DIV;
            phase = pos % DIV;
            e.lit  = enable && (phase >= DEAD) && !leading_zero(m_active, slot);
            e.sym  = field_of(m_active, slot);
            e.didx = 2'(slot);
            e.an   = e.lit ? ~(4'b0001 << (N_DIG - 1 - slot)) : 4'hF;
            e.seg  = e.lit ? SEG_TAB[e.sym] : 7'h7F;
            e.fd   = enable && (pos == FRAME - 1);
            boundary = e.fd;
            if (!enable || boundary) begin
                if (load) m_active = disps;
                else if (m_pv) m_active = m_pending;
                m_pv = 0;
            end else if (load) begin
                m_pending = disps;
                m_pv = 1;
            end
            pos = enable ? (pos + 1) % FRAME : 0;
        end
        exp_q.push_back(e);
    end

    // Monitor: compares every presented output word against the scoreboard.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("AN", 32'(AN), 32'(e.an));
            chk("seven_out", 32'(seven_out), 32'(e.seg));
            chk("frame_done", 32'(frame_done), 32'(e.fd));
            if (e.lit) begin
                chk("sym_out", 32'(sym_out), 32'(e.sym));
                chk("digit_idx", 32'(digit_idx), 32'(e.didx));
            end
        end
    end

    task automatic step(input bit en, input bit ld, input logic [N_DIG*SYM_W-1:0] v);
        enable = en;
        load   = ld;
        disps  = v;
        @(negedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 20'($urandom));
    endtask

    task automatic wait_pos(input int unsigned target);
        for (int i = 0; i < 2 * FRAME && pos != target; i++) step(1, 0, 20'($urandom));
        chk("wait_pos_reached", 32'(pos), 32'(target));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Load while disabled commits directly; then two full frames of 3,3,5,5.
        step(0, 1, 20'h18CA5);
        run(2 * FRAME + 4);

        // Mid-frame load in slot 1 waits for the frame boundary.
        wait_pos(DIV + 3);
        step(1, 1, 20'($urandom));
        run(FRAME + 8);

        // Two loads in one frame: only the second is shown.
        wait_pos(5);
        step(1, 1, 20'($urandom));
        run(6);
        step(1, 1, 20'($urandom));
        run(FRAME + 8);

        // Load in the boundary cycle goes straight to the next frame.
        wait_pos(FRAME - 1);
        step(1, 1, 20'($urandom));
        run(FRAME + 4);

        // Leading-zero patterns.
        wait_pos(10);
        step(1, 1, 20'h00005);
        run(2 * FRAME);
        step(1, 1, 20'h00000);
        run(2 * FRAME);

        // Enable dropped in slot 2, then re-enabled.
        wait_pos(2 * DIV + 3);
        step(0, 0, 20'($urandom));
        step(0, 0, 20'($urandom));
        step(0, 0, 20'($urandom));
        run(FRAME + 4);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step(($urandom % 50) != 0, ($urandom % 8) == 0, 20'($urandom));

        // Reset mid-slot with a pending load.
        wait_pos(DIV + 4);
        step(1, 1, 20'hFFFFF);
        rst_n = 1'b0;
        #1;
        chk("async_reset_AN", 32'(AN), 32'hF);
        chk("async_reset_seg", 32'(seven_out), 32'h7F);
        step(1, 0, 20'($urandom));
        step(1, 0, 20'($urandom));
        rst_n = 1'b1;
        run(2 * FRAME);

        step(1, 0, 20'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
